lut_neuron_prog: RTL and testbench

Runtime-programmable LUT neuron. It is the write-side counterpart to the fixed, synthesized truth-table neurons in the layer netlists. A truth table of 2^IN_BITS entries × OUT_BITS is streamed in over a valid/ready configuration port and stored in distributed RAM. The block then serves registered lookups on the activation path. It lets a layer slot be re-trained and reloaded without resynthesis.

---
 rtl/lut_neuron_prog.sv | 142 ++++++++++++++
 tb/tb_lut_neuron_prog.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_prog.sv
// lut_neuron_prog: runtime-programmable LUT neuron.
// A truth table of 2^IN_BITS entries x OUT_BITS is streamed in over a
// valid/ready configuration port, then served as registered lookups.
// Optional feature macro: LUT_PARITY_EN (even-parity check on cfg_data).
module lut_neuron_prog #(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WR_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WR_W-1:0]     cfg_data,
    output logic                cfg_done,
    output logic                cfg_err,
`ifdef LUT_PARITY_EN
    input  logic                cfg_par,
`endif
    input  logic                in_valid,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data
);

    localparam int TBITS = (2 ** IN_BITS) * OUT_BITS;
    localparam int WORDS = TBITS / WR_W;
    localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED
    } state_t;

    state_t                state_q;
    logic [KW-1:0]         k_q;
    logic                  ready_q;
    logic                  done_q;
    logic                  valid_q;
    logic [OUT_BITS-1:0]   data_q;
    logic [TBITS-1:0]      table_q;

    logic                  hs;
    logic                  last_hs;
    logic                  load_ok;

    // Handshake qualification; cfg_start overrides any word offered in the same cycle
    always_comb begin
        hs      = (state_q == LOAD) && cfg_valid && !cfg_start;
        last_hs = hs && (k_q == K_LAST);
    end

`ifdef LUT_PARITY_EN
    logic err_q;
    logic par_bad;

    // Parity mismatch on the word being accepted this cycle
    always_comb begin
        par_bad = hs && ((^cfg_data) != cfg_par);
        load_ok = !(err_q || par_bad);
    end

    // Sticky error flag, cleared by reset or a new load
    always_ff @(posedge clk) begin
        if (rst || cfg_start) begin
            err_q <= 1'b0;
        end else if (par_bad) begin
            err_q <= 1'b1;
        end
    end

    assign cfg_err = err_q;
`else
    // Without parity checking every completed load arms the table
    always_comb begin
        load_ok = 1'b1;
    end

    assign cfg_err = 1'b0;
`endif

    // Table storage: no reset, written one word per accepted handshake
    always_ff @(posedge clk) begin
        if (hs && !rst) begin
            table_q[k_q*WR_W +: WR_W] <= cfg_data;
        end
    end

    // Control FSM with registered handshake, done and lookup outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            if (cfg_start) begin
                state_q <= LOAD;
                k_q     <= '0;
                ready_q <= 1'b1;
            end else begin
                case (state_q)
                    LOAD: begin
                        if (last_hs) begin
                            state_q <= load_ok ? ARMED : IDLE;
                            k_q     <= '0;
                            ready_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (hs) begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                    ARMED: begin
                        if (in_valid) begin
                            valid_q <= 1'b1;
                            data_q  <= table_q[in_data*OUT_BITS +: OUT_BITS];
                        end
                    end
                    IDLE: begin
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Testbench for lut_neuron_prog (default parameters: 256 x 1-bit table, 8-bit words).
// Reference model: a flat bit array of table entries built from the words loaded.
module tb_lut_neuron_prog;

    localparam int IN_BITS  = 8;
    localparam int OUT_BITS = 1;
    localparam int WR_W     = 8;
    localparam int WORDS    = 32;
    localparam int ENTRIES  = 256;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_start;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [WR_W-1:0]     cfg_data;
    logic                cfg_done;
    logic                cfg_err;
`ifdef LUT_PARITY_EN
    logic                cfg_par;
`endif
    logic                in_valid;
    logic [IN_BITS-1:0]  in_data;
    logic                out_valid;
    logic [OUT_BITS-1:0] out_data;

    logic [WR_W-1:0]     wbuf [WORDS];
    logic                ref_tab [ENTRIES];
    int                  n_cmp = 0;
    int                  n_err = 0;

    always #5 clk = ~clk;

    lut_neuron_prog #(
        .IN_BITS (IN_BITS),
        .OUT_BITS(OUT_BITS),
        .WR_W    (WR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_data (cfg_data),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err),
`ifdef LUT_PARITY_EN
        .cfg_par  (cfg_par),
`endif
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    // Advance one clock and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entry a is flat table bit a: word k bit j lands at entry k*WR_W + j
    task automatic model_commit();
        for (int k = 0; k < WORDS; k++)
            for (int j = 0; j < WR_W; j++)
                ref_tab[k*WR_W + j] = wbuf[k][j];
    endtask

    task automatic fill_random();
        for (int k = 0; k < WORDS; k++) wbuf[k] = WR_W'($urandom);
    endtask

    // Full load of wbuf; bad_idx >= 0 corrupts parity of that word
    task automatic do_load(input bit toggle, input int bad_idx, input string tag);
        int  pulses;
        logic [IN_BITS-1:0] a;
        logic good;
        good   = (bad_idx < 0);
        pulses = 0;
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_cmp++;
        if (cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_after_start: got %0b want 1", tag, cfg_ready);
        end
        for (int w = 0; w < WORDS; w++) begin
            if (toggle) begin
                cfg_valid = 1'b0;
                cfg_data  = WR_W'($urandom);
                tick();
                if (cfg_done === 1'b1) pulses++;
            end
            cfg_valid = 1'b1;
            cfg_data  = wbuf[w];
`ifdef LUT_PARITY_EN
            cfg_par   = (^wbuf[w]) ^ (w == bad_idx);
`endif
            tick();
            if (cfg_done === 1'b1) pulses++;
`ifdef LUT_PARITY_EN
            if (w == bad_idx) begin
                n_cmp++;
                if (cfg_err !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s err_after_bad_word: got %0b want 1", tag, cfg_err);
                end
            end
`endif
        end
        cfg_valid = 1'b0;
        // Just after the final handshake edge: done high, ready low
        n_cmp++;
        if (cfg_done !== 1'b1 || pulses != 1) begin
            n_err++;
            $display("FAIL %s done_pulse: got done=%0b pulses=%0d want done=1 pulses=1", tag, cfg_done, pulses);
        end
        n_cmp++;
        if (cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s ready_after_load: got %0b want 0", tag, cfg_ready);
        end
        if (good) model_commit();
        // First lookup offered in the done cycle
        a        = IN_BITS'($urandom);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (cfg_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_single_cycle: got %0b want 0", tag, cfg_done);
        end
        n_cmp++;
        if (out_valid !== good || (good && out_data !== ref_tab[a])) begin
            n_err++;
            $display("FAIL %s first_lookup: got v=%0b d=%0h want v=%0b d=%0h",
                     tag, out_valid, out_data, good, ref_tab[a]);
        end
`ifdef LUT_PARITY_EN
        n_cmp++;
        if (cfg_err !== !good) begin
            n_err++;
            $display("FAIL %s err_flag: got %0b want %0b", tag, cfg_err, !good);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        in_valid = 1'b0; in_data = '0;
`ifdef LUT_PARITY_EN
        cfg_par = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        in_valid = 1'b1;
        in_data  = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || cfg_ready !== 1'b0 || cfg_done !== 1'b0 ||
                cfg_err !== 1'b0 || out_data !== '0) begin
                n_err++;
                $display("FAIL reset_state: got v=%0b rdy=%0b done=%0b err=%0b d=%0h want all 0",
                         out_valid, cfg_ready, cfg_done, cfg_err, out_data);
            end
        end
        in_valid = 1'b0;
    endtask

    // Single registered lookup checked against the model
    task automatic lookup(input logic [IN_BITS-1:0] a, input string tag);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ref_tab[a]) begin
            n_err++;
            $display("FAIL %s lookup_%0h: got v=%0b d=%0h want v=1 d=%0h",
                     tag, a, out_valid, out_data, ref_tab[a]);
        end
    endtask

    task automatic test_load_basic();
        for (int k = 0; k < WORDS; k++) wbuf[k] = '0;
        wbuf[8] = 8'hFF;
        do_load(1'b0, -1, "basic");
        lookup(8'h40, "basic");
        lookup(8'h47, "basic");
        lookup(8'h3F, "basic");
        lookup(8'h48, "basic");
    endtask

    task automatic test_toggle_valid();
        // Scramble the table first so a correct result can only come from the toggled load
        fill_random();
        do_load(1'b0, -1, "pre_toggle");
        for (int k = 0; k < WORDS; k++) wbuf[k] = '0;
        wbuf[8] = 8'hFF;
        do_load(1'b1, -1, "toggle");
        lookup(8'h40, "toggle");
        lookup(8'h47, "toggle");
        lookup(8'h3F, "toggle");
        lookup(8'h48, "toggle");
        for (int i = 0; i < 8; i++) lookup(IN_BITS'($urandom), "toggle");
    endtask

    task automatic test_start_armed();
        in_valid  = 1'b1;
        in_data   = 8'h40;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        in_valid  = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || cfg_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_armed: got v=%0b rdy=%0b want v=0 rdy=1", out_valid, cfg_ready);
        end
        for (int k = 0; k < WORDS; k++) wbuf[k] = 8'hFF;
        do_load(1'b0, -1, "reload_ff");
        lookup(8'h00, "reload_ff");
    endtask

    task automatic test_reset_midload();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int w = 0; w < 10; w++) begin
            cfg_valid = 1'b1;
            cfg_data  = WR_W'($urandom);
`ifdef LUT_PARITY_EN
            cfg_par   = ^cfg_data;
`endif
            tick();
        end
        cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = IN_BITS'($urandom);
            tick();
            n_cmp++;
            if (cfg_done !== 1'b0 || cfg_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL midload_reset: got done=%0b rdy=%0b v=%0b want 0 0 0",
                         cfg_done, cfg_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        fill_random();
        do_load(1'b0, -1, "after_reset");
        for (int i = 0; i < 8; i++) lookup(IN_BITS'($urandom), "after_reset");
    endtask

    task automatic test_restart_midload();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int w = 0; w < 7; w++) begin
            cfg_valid = 1'b1;
            cfg_data  = WR_W'($urandom);
`ifdef LUT_PARITY_EN
            cfg_par   = ^cfg_data;
`endif
            tick();
        end
        cfg_valid = 1'b0;
        fill_random();
        do_load(1'b0, -1, "restart");
        for (int i = 0; i < 8; i++) lookup(IN_BITS'($urandom), "restart");
    endtask

    // Random in_valid every cycle; out_data must hold when no lookup is issued
    task automatic test_back_to_back();
        logic               pv;
        logic [OUT_BITS-1:0] hold;
        logic [IN_BITS-1:0] a;
        a        = IN_BITS'($urandom);
        in_valid = 1'b1;
        in_data  = a;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== ref_tab[a]) begin
            n_err++;
            $display("FAIL b2b_first: got v=%0b d=%0h want v=1 d=%0h", out_valid, out_data, ref_tab[a]);
        end
        hold = ref_tab[a];
        for (int i = 0; i < 200; i++) begin
            pv       = 1'($urandom_range(0, 1));
            a        = IN_BITS'($urandom);
            in_valid = pv;
            in_data  = a;
            tick();
            if (pv) hold = ref_tab[a];
            n_cmp++;
            if (out_valid !== pv || out_data !== hold) begin
                n_err++;
                $display("FAIL b2b_%0d: got v=%0b d=%0h want v=%0b d=%0h", i, out_valid, out_data, pv, hold);
            end
        end
        in_valid = 1'b0;
    endtask

`ifdef LUT_PARITY_EN
    task automatic test_parity();
        fill_random();
        do_load(1'b0, 5, "parity_bad");
        in_valid = 1'b1;
        in_data  = IN_BITS'($urandom);
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || cfg_ready !== 1'b0) begin
            n_err++;
            $display("FAIL parity_idle: got v=%0b rdy=%0b want 0 0", out_valid, cfg_ready);
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        n_cmp++;
        if (cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_clear: got %0b want 0", cfg_err);
        end
        fill_random();
        do_load(1'b0, -1, "parity_good");
        for (int i = 0; i < 8; i++) lookup(IN_BITS'($urandom), "parity_good");
    endtask
`endif

    initial begin
        test_reset();
        test_load_basic();
        test_toggle_valid();
        test_start_armed();
        test_reset_midload();
        test_restart_midload();
        test_back_to_back();
`ifdef LUT_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
